// File: rtl/ipf_core.sv
// ipf_core: 3x3 median / max / gradient filter over a 256x256 8-bit frame.
// Streams one pixel read per cycle into a sliding 3-column window and writes one 9-bit result per pixel.
module ipf_core #(
  parameter int In_Width   = 8,
  parameter int Out_Width  = 9,
  parameter int Addr_Width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  gray_ready,
  output logic                  gray_req,
  output logic [Addr_Width-1:0] gray_addr,
  input  logic [In_Width-1:0]   gray_data,
  output logic                  ipf_valid,
  output logic [Addr_Width-1:0] ipf_addr,
  output logic [Out_Width-1:0]  ipf_data,
  output logic                  finish
);

  localparam int Side_Bits = Addr_Width / 2;
  localparam logic [Side_Bits-1:0] Row_One = {{(Side_Bits-1){1'b0}}, 1'b1};
  localparam logic [Side_Bits:0]   Col_One = {{Side_Bits{1'b0}}, 1'b1};
  localparam logic [Side_Bits+1:0] Rr_One  = {{(Side_Bits+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [Side_Bits-1:0]  fr_q, fr_d;        // pixel row whose window column is being fetched
  logic [Side_Bits:0]    fc_q, fc_d;        // fetched column, 0..256
  logic [1:0]            fk_q, fk_d;        // window row being fetched (row fr-1+fk)
  logic                  fvalid_q, fvalid_d;
  logic                  req_q, req_d;
  logic [Addr_Width-1:0] raddr_q, raddr_d;
  logic                  full_q, full_d;
  logic [Addr_Width-1:0] pix_addr_q, pix_addr_d;
  logic                  wvalid_q, wvalid_d;
  logic [Addr_Width-1:0] waddr_q, waddr_d;
  logic [Out_Width-1:0]  wdata_q, wdata_d;
  logic                  finish_q, finish_d;
  logic [In_Width-1:0]   win_q [0:2][0:2];
  logic [In_Width-1:0]   pix_s;
  logic [Out_Width-1:0]  result_s;
  logic [Side_Bits+1:0]  rr_s;

  assign gray_req  = req_q;
  assign gray_addr = raddr_q;
  assign ipf_valid = wvalid_q;
  assign ipf_addr  = waddr_q;
  assign ipf_data  = wdata_q;
  assign finish    = finish_q;
  assign pix_s     = req_q ? gray_data : {In_Width{1'b0}};

  // Filter datapath: median by rank counting, max, and |E-W| + |S-N|.
  always_comb begin
    logic [In_Width-1:0] v [0:8];
    logic [3:0]          lt;
    logic [3:0]          le;
    logic [In_Width-1:0] med;
    logic [In_Width-1:0] mx;
    logic [In_Width-1:0] ew;
    logic [In_Width-1:0] sn;
    v[0] = win_q[0][0]; v[1] = win_q[0][1]; v[2] = win_q[0][2];
    v[3] = win_q[1][0]; v[4] = win_q[1][1]; v[5] = win_q[1][2];
    v[6] = win_q[2][0]; v[7] = win_q[2][1]; v[8] = win_q[2][2];
    med = {In_Width{1'b0}};
    mx  = {In_Width{1'b0}};
    for (int i = 0; i < 9; i++) begin
      lt = 4'd0;
      le = 4'd0;
      for (int j = 0; j < 9; j++) begin
        lt = lt + {3'd0, (v[j] < v[i])};
        le = le + {3'd0, (v[j] <= v[i])};
      end
      if (lt <= 4'd4 && le >= 4'd5) med = v[i];
      else                          med = med;
      if (v[i] > mx) mx = v[i];
      else           mx = mx;
    end
    ew = (v[5] >= v[3]) ? (v[5] - v[3]) : (v[3] - v[5]);
    sn = (v[7] >= v[1]) ? (v[7] - v[1]) : (v[1] - v[7]);
    case (mode_q)
      2'd1:    result_s = Out_Width'(mx);
      2'd2:    result_s = Out_Width'(ew) + Out_Width'(sn);
      default: result_s = Out_Width'(med);
    endcase
  end

  // Next-state: fetch sequencer, write strobe and frame control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fr_d       = fr_q;
    fc_d       = fc_q;
    fk_d       = fk_q;
    fvalid_d   = fvalid_q;
    full_d     = 1'b0;
    pix_addr_d = pix_addr_q;
    wvalid_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    finish_d   = finish_q;
    case (state_q)
      S_IDLE: begin
        waddr_d  = {Addr_Width{1'b0}};
        wdata_d  = {Out_Width{1'b0}};
        finish_d = 1'b0;
        if (gray_ready) begin
          state_d  = S_RUN;
          mode_d   = (mode == 2'd3) ? 2'd0 : mode;
          fr_d     = {Side_Bits{1'b0}};
          fc_d     = {(Side_Bits+1){1'b0}};
          fk_d     = 2'd0;
          fvalid_d = 1'b1;
        end else begin
          fvalid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (fvalid_q) begin
          // The window holds pixel fc-1 once the last row of column fc lands.
          full_d     = (fk_q == 2'd2) && (fc_q != {(Side_Bits+1){1'b0}});
          pix_addr_d = {fr_q, fc_q[Side_Bits-1:0] - Row_One};
          if (fk_q != 2'd2) begin
            fk_d = fk_q + 2'd1;
          end else begin
            fk_d = 2'd0;
            if (!fc_q[Side_Bits]) begin
              fc_d = fc_q + Col_One;
            end else begin
              fc_d = {(Side_Bits+1){1'b0}};
              if (fr_q != {Side_Bits{1'b1}}) fr_d = fr_q + Row_One;
              else                           fvalid_d = 1'b0;
            end
          end
        end else begin
          fvalid_d = 1'b0;
        end
        if (full_q) begin
          wvalid_d = 1'b1;
          waddr_d  = pix_addr_q;
          wdata_d  = result_s;
        end else begin
          wvalid_d = 1'b0;
        end
        if (wvalid_q && (waddr_q == {Addr_Width{1'b1}})) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        finish_d = 1'b1;
        fvalid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    rr_s    = {2'b00, fr_d} + {{Side_Bits{1'b0}}, fk_d} - Rr_One;
    req_d   = fvalid_d && (rr_s[Side_Bits+1:Side_Bits] == 2'b00) && !fc_d[Side_Bits];
    raddr_d = req_d ? {rr_s[Side_Bits-1:0], fc_d[Side_Bits-1:0]} : {Addr_Width{1'b0}};
  end

  // State, output and window registers; window shifts when a new column starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      fr_q       <= {Side_Bits{1'b0}};
      fc_q       <= {(Side_Bits+1){1'b0}};
      fk_q       <= 2'd0;
      fvalid_q   <= 1'b0;
      req_q      <= 1'b0;
      raddr_q    <= {Addr_Width{1'b0}};
      full_q     <= 1'b0;
      pix_addr_q <= {Addr_Width{1'b0}};
      wvalid_q   <= 1'b0;
      waddr_q    <= {Addr_Width{1'b0}};
      wdata_q    <= {Out_Width{1'b0}};
      finish_q   <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        for (int m = 0; m < 3; m++) win_q[k][m] <= {In_Width{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fr_q       <= fr_d;
      fc_q       <= fc_d;
      fk_q       <= fk_d;
      fvalid_q   <= fvalid_d;
      req_q      <= req_d;
      raddr_q    <= raddr_d;
      full_q     <= full_d;
      pix_addr_q <= pix_addr_d;
      wvalid_q   <= wvalid_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      finish_q   <= finish_d;
      if (state_q == S_RUN && fvalid_q) begin
        if (fk_q == 2'd0) begin
          // Column 0 starts a row: column -1 and the previous row's columns become zero.
          for (int k = 0; k < 3; k++) begin
            win_q[k][0] <= (fc_q == {(Side_Bits+1){1'b0}}) ? {In_Width{1'b0}} : win_q[k][1];
            win_q[k][1] <= (fc_q == {(Side_Bits+1){1'b0}}) ? {In_Width{1'b0}} : win_q[k][2];
          end
          win_q[0][2] <= pix_s;
        end else begin
          win_q[fk_q][2] <= pix_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipf_core.sv
// Scoreboard bench for ipf_core: random and directed images, reference results
// computed from the filter definitions and compared as the DUT writes them.
module tb_ipf_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        gray_ready = 1'b0;
  logic        gray_req;
  logic [15:0] gray_addr;
  logic [7:0]  gray_data;
  logic        ipf_valid;
  logic [15:0] ipf_addr;
  logic [8:0]  ipf_data;
  logic        finish;

  ipf_core dut (
    .clk(clk), .rst(rst), .mode(mode), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .ipf_valid(ipf_valid), .ipf_addr(ipf_addr), .ipf_data(ipf_data),
    .finish(finish)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:65535];
  logic [7:0] junk = 8'd0;
  int         cyc = 0;

  // Source memory: zero-wait read; garbage on the bus when not requested.
  assign gray_data = gray_req ? img[gray_addr] : junk;
  always @(posedge clk) begin
    junk <= 8'($urandom);
    cyc  <= cyc + 1;
  end

  typedef struct packed { logic [15:0] a; logic [8:0] d; } exp_t;
  exp_t exp_q[$];
  int   spot[int];
  int   checks = 0;
  int   passed = 0;
  int   rx = 0;
  int   last_valid_cyc = 0;
  logic fuzz = 1'b0;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  function automatic int px(int r, int c);
    if (r < 0 || r > 255 || c < 0 || c > 255) return 0;
    return int'(img[r*256 + c]);
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int model(int m, int r, int c);
    int v[9];
    int t;
    int best;
    for (int i = 0; i < 9; i++) v[i] = px(r - 1 + i / 3, c - 1 + i % 3);
    if (m == 1) begin
      best = 0;
      for (int i = 0; i < 9; i++) if (v[i] > best) best = v[i];
      return best;
    end
    if (m == 2) return iabs(px(r, c+1) - px(r, c-1)) + iabs(px(r+1, c) - px(r-1, c));
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[4];
  endfunction

  task automatic fill(int kind);
    for (int a = 0; a < 65536; a++) begin
      case (kind)
        0:       img[a] = 8'd100;
        1:       img[a] = 8'(a % 256);
        2:       img[a] = (a == 10*256 + 10) ? 8'd255 : 8'd0;
        default: img[a] = 8'($urandom);
      endcase
    end
  endtask

  task automatic start(int m);
    exp_q.delete();
    for (int a = 0; a < 65536; a++) exp_q.push_back('{16'(a), 9'(model(m, a / 256, a % 256))});
    rx = 0;
    @(posedge clk); #1;
    mode = 2'(m);
    gray_ready = 1'b1;
    @(posedge clk); #1;
    gray_ready = 1'b0;
    fuzz = 1'b1;
  endtask

  task automatic wait_rx(int n);
    int budget;
    budget = 4*n + 2000;
    while (rx < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (fuzz) begin mode = 2'($urandom); gray_ready = 1'($urandom); end
    end
    check("results arrive in time", (rx >= n), 1);
  endtask

  task automatic pulse_rst();
    fuzz = 1'b0;
    gray_ready = 1'b0;
    mode = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("outputs after reset", {gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, finish}, 0);
    exp_q.delete();
    spot.delete();
  endtask

  task automatic partial(int kind, int m, int rows);
    fill(kind);
    start(m);
    wait_rx(rows*256 + 128);
    pulse_rst();
  endtask

  initial begin
    int n;
    int fin_cyc;
    exp_t e;

    // Monitor: pops the scoreboard on every write strobe.
    fork
      forever begin
        @(negedge clk);
        if (ipf_valid) begin
          last_valid_cyc = cyc;
          rx++;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected write: addr %0d data %0d, expected no write", ipf_addr, ipf_data);
          end else begin
            e = exp_q.pop_front();
            if (ipf_addr == e.a && ipf_data == e.d) passed++;
            else $display("FAIL write: addr %0d data %0d, expected addr %0d data %0d",
                          ipf_addr, ipf_data, e.a, e.d);
          end
          if (spot.exists(int'(ipf_addr)))
            check("test-plan point", ipf_data, spot[int'(ipf_addr)]);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset state", {gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, finish}, 0);

    spot[0] = 0; spot[255] = 0; spot[5] = 100; spot[5*256] = 100; spot[3*256+4] = 100;
    partial(0, 0, 8);
    spot[0] = 100; spot[255] = 100; spot[3*256+7] = 100;
    partial(0, 1, 8);
    spot[0] = 200; spot[5] = 100; spot[3*256+3] = 0;
    partial(0, 2, 8);
    spot[3*256+3] = 2; spot[5*256] = 1; spot[5*256+255] = 254;
    partial(1, 2, 8);
    spot[10*256+10] = 0; spot[9*256+9] = 0; spot[11*256+11] = 0;
    partial(2, 0, 12);
    spot[9*256+9] = 255; spot[11*256+11] = 255; spot[10*256+10] = 255;
    spot[8*256+10] = 0; spot[10*256+12] = 0; spot[12*256+10] = 0;
    partial(2, 1, 12);
    partial(3, 3, 100);

    // Full frame after a mid-row reset.
    fill(3);
    start($urandom_range(0, 3));
    n = 0;
    fin_cyc = 0;
    while (!finish && n < 210000) begin
      @(negedge clk);
      n++;
      if (finish) fin_cyc = cyc;
      else begin mode = 2'($urandom); gray_ready = 1'($urandom); end
    end
    check("finish within 210000 cycles", finish, 1);
    check("results written", rx, 65536);
    check("scoreboard drained", exp_q.size(), 0);
    check("finish after last write", (fin_cyc > last_valid_cyc), 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mode = 2'($urandom);
      gray_ready = 1'($urandom);
      check("done state held", {finish, gray_req, ipf_valid}, 3'b100);
    end
    pulse_rst();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
